// File: rtl/dual_port_ram_be_if.sv
// Port-A write / port-B read bus for dual_port_ram_be, with clear request and busy status.
// The master drives the requests and the slave (the RAM) returns read data and status.
interface dual_port_ram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  clear_req;
  logic                  a_we;
  logic [BE_WIDTH-1:0]   a_be;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_din;
  logic                  b_re;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_dout;
  logic                  b_valid;
  logic                  busy;

  modport master (
    output clear_req, a_we, a_be, a_addr, a_din, b_re, b_addr,
    input  b_dout, b_valid, busy
  );

  modport slave (
    input  clear_req, a_we, a_be, a_addr, a_din, b_re, b_addr,
    output b_dout, b_valid, busy
  );
endinterface

// File: rtl/dual_port_ram_be.sv
// Simple dual-port RAM with byte enables, selectable read-during-write policy and a clear engine.
// Define DPRAM_OUT_REG_EN to add an output pipeline register, which gives a read latency of 2.
module dual_port_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int RDW_MODE   = 0
) (
  input  logic             clk,
  input  logic             reset,
  dual_port_ram_be_if.slave bus
);
  localparam int DEPTH    = 2 ** ADDR_WIDTH;
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  typedef enum logic { S_CLEAR, S_READY } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_WIDTH-1:0] b_dout_q, b_dout_d;
  logic                  b_valid_q, b_valid_d;

  logic [DATA_WIDTH-1:0] ram [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged_word;
  logic                  wr_en;
  logic                  rd_en;
  logic                  collide;

  // NOTE: every signal gets a default at the top of always_comb, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      S_CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) state_d = S_READY;
      end
      S_READY: begin
        if (bus.clear_req) begin
          state_d   = S_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Accesses are dropped entirely while the clear engine owns the array.
  always_comb begin
    wr_en   = bus.a_we && (state_q == S_READY);
    rd_en   = bus.b_re && (state_q == S_READY);
    collide = wr_en && (bus.a_addr == bus.b_addr);
    rd_word = ram[bus.b_addr];
    for (int i = 0; i < BE_WIDTH; i++) begin
      merged_word[8*i +: 8] = bus.a_be[i] ? bus.a_din[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  always_comb begin
    b_valid_d = rd_en;
    b_dout_d  = b_dout_q;
    if (rd_en) b_dout_d = (RDW_MODE == 1 && collide) ? merged_word : rd_word;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
      b_dout_q  <= '0;
      b_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      b_dout_q  <= b_dout_d;
      b_valid_q <= b_valid_d;
    end
  end

  // NOTE: the array has no reset; the clear engine zeroes it, so the storage can still map onto block RAM.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      ram[clr_ptr_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < BE_WIDTH; i++) begin
        if (bus.a_be[i]) ram[bus.a_addr][8*i +: 8] <= bus.a_din[8*i +: 8];
      end
    end
  end

  assign bus.busy = (state_q == S_CLEAR);

`ifdef DPRAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_dout_q;
  logic                  out_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_dout_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_dout_q  <= b_dout_q;
      out_valid_q <= b_valid_q;
    end
  end

  assign bus.b_dout  = out_dout_q;
  assign bus.b_valid = out_valid_q;
`else
  assign bus.b_dout  = b_dout_q;
  assign bus.b_valid = b_valid_q;
`endif
endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench for dual_port_ram_be: one instance with RDW_MODE=0 and one with RDW_MODE=1 share the same stimulus.
// Each instance has its own expected-response queue and its own monitor.
module tb_dual_port_ram_be;
`ifdef DPRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req, a_we, b_re;
  logic [3:0]  a_be, a_addr, b_addr;
  logic [31:0] a_din;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  dual_port_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if0 ();
  dual_port_ram_be_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if1 ();

  assign if0.clear_req = clear_req;
  assign if0.a_we      = a_we;
  assign if0.a_be      = a_be;
  assign if0.a_addr    = a_addr;
  assign if0.a_din     = a_din;
  assign if0.b_re      = b_re;
  assign if0.b_addr    = b_addr;
  assign if1.clear_req = clear_req;
  assign if1.a_we      = a_we;
  assign if1.a_be      = a_be;
  assign if1.a_addr    = a_addr;
  assign if1.a_din     = a_din;
  assign if1.b_re      = b_re;
  assign if1.b_addr    = b_addr;

  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .bus(if0)
  );
  dual_port_ram_be #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitors: whenever b_valid is high, pop the oldest expectation and compare data and arrival cycle.
  always @(negedge clk) begin
    if (if0.b_valid === 1'b1) begin
      if (q0.size() == 0) check("rdw0_unexpected_valid", 32'd1, 32'd0);
      else begin
        e0 = q0.pop_front();
        check("rdw0_data", if0.b_dout, e0.data);
        check("rdw0_latency", 32'(cyc), 32'(e0.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (if1.b_valid === 1'b1) begin
      if (q1.size() == 0) check("rdw1_unexpected_valid", 32'd1, 32'd0);
      else begin
        e1 = q1.pop_front();
        check("rdw1_data", if1.b_dout, e1.data);
        check("rdw1_latency", 32'(cyc), 32'(e1.cyc));
      end
    end
  end

  task automatic ops_off();
    clear_req = 1'b0; a_we = 1'b0; b_re = 1'b0;
    a_be = '0; a_addr = '0; a_din = '0; b_addr = '0;
  endtask

  task automatic idle();
    @(posedge clk); #1;
    ops_off();
  endtask

  task automatic wr(input logic [3:0] addr, input logic [3:0] be, input logic [31:0] din);
    @(posedge clk); #1;
    ops_off();
    a_we = 1'b1; a_addr = addr; a_be = be; a_din = din;
  endtask

  task automatic rd(input logic [3:0] addr, input logic [31:0] exp0, input logic [31:0] exp1);
    @(posedge clk); #1;
    ops_off();
    b_re = 1'b1; b_addr = addr;
    q0.push_back('{data: exp0, cyc: cyc + LAT});
    q1.push_back('{data: exp1, cyc: cyc + LAT});
  endtask

  task automatic wr_rd(input logic [3:0] waddr, input logic [3:0] be, input logic [31:0] din,
                       input logic [3:0] raddr, input logic [31:0] exp0, input logic [31:0] exp1);
    @(posedge clk); #1;
    ops_off();
    a_we = 1'b1; a_addr = waddr; a_be = be; a_din = din;
    b_re = 1'b1; b_addr = raddr;
    q0.push_back('{data: exp0, cyc: cyc + LAT});
    q1.push_back('{data: exp1, cyc: cyc + LAT});
  endtask

  // Clear request together with a write to address 10; the clear must overwrite it.
  task automatic clr();
    @(posedge clk); #1;
    ops_off();
    clear_req = 1'b1;
    a_we = 1'b1; a_addr = 4'd10; a_be = 4'hF; a_din = 32'h1010_1010;
  endtask

  // Write and read attempts held through a busy window; none may take effect.
  task automatic busy_op();
    @(posedge clk); #1;
    ops_off();
    a_we = 1'b1; a_addr = 4'd9; a_be = 4'hF; a_din = 32'hFFFF_FFFF;
    b_re = 1'b1; b_addr = 4'd9;
  endtask

  task automatic count_busy(input string name);
    int n0 = 0;
    int n1 = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (if0.busy === 1'b1) n0++;
      if (if1.busy === 1'b1) n1++;
      if (if0.busy !== 1'b1 && if1.busy !== 1'b1) break;
    end
    ops_off();
    check({name, "_rdw0"}, 32'(n0), 32'd16);
    check({name, "_rdw1"}, 32'(n1), 32'd16);
  endtask

  task automatic check_reset_state(input string name);
    check({name, "_busy0"},  {31'd0, if0.busy},    32'd1);
    check({name, "_busy1"},  {31'd0, if1.busy},    32'd1);
    check({name, "_valid0"}, {31'd0, if0.b_valid}, 32'd0);
    check({name, "_valid1"}, {31'd0, if1.b_valid}, 32'd0);
    check({name, "_dout0"},  if0.b_dout,           32'd0);
    check({name, "_dout1"},  if1.b_dout,           32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    ops_off();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy("por_busy");
    for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, 32'd0);

    // Byte-enable merge and a_be=0 no-op.
    wr(4'd3, 4'hF, 32'hA1B2_C3D4);
    wr(4'd3, 4'b0101, 32'h1122_3344);
    rd(4'd3, 32'hA122_C344, 32'hA122_C344);
    wr(4'd3, 4'h0, 32'hFFFF_FFFF);
    rd(4'd3, 32'hA122_C344, 32'hA122_C344);

    // Read-during-write collisions, full and partial, then an independent address pair.
    wr(4'd5, 4'hF, 32'h1234_5678);
    wr_rd(4'd5, 4'hF, 32'hDEAD_BEEF, 4'd5, 32'h1234_5678, 32'hDEAD_BEEF);
    rd(4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    wr_rd(4'd6, 4'b0011, 32'hAABB_CCDD, 4'd6, 32'h0000_0000, 32'h0000_CCDD);
    rd(4'd6, 32'h0000_CCDD, 32'h0000_CCDD);
    wr_rd(4'd7, 4'hF, 32'h7777_7777, 4'd3, 32'hA122_C344, 32'hA122_C344);
    rd(4'd3, 32'hA122_C344, 32'hA122_C344);
    rd(4'd5, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    rd(4'd7, 32'h7777_7777, 32'h7777_7777);

    // Reset in the middle of a requested clear: dout holds while busy, then resets to 0.
    clr();
    busy_op();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("busy_hold_dout0", if0.b_dout, 32'h7777_7777);
    check("busy_hold_dout1", if1.b_dout, 32'h7777_7777);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check_reset_state("mid");
    @(posedge clk); #1;
    reset = 1'b0;
    count_busy("mid_busy");
    rd(4'd9, 32'd0, 32'd0);
    rd(4'd10, 32'd0, 32'd0);
    rd(4'd3, 32'd0, 32'd0);

    // Fill, spot-check, then a clear request with accesses held during busy.
    for (int a = 0; a < 16; a++) wr(4'(a), 4'hF, 32'h0101_0101 * 32'(a + 1));
    rd(4'd4, 32'h0505_0505, 32'h0505_0505);
    rd(4'd15, 32'h1010_1010, 32'h1010_1010);
    clr();
    busy_op();
    count_busy("req_busy");
    for (int a = 0; a < 16; a++) rd(4'(a), 32'd0, 32'd0);

    repeat (6) idle();
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
